// File: rtl/inputc_nvc_pkg.sv
// inputc_pkg: flit/port codes, flit field offsets and per-VC FSM states shared by the input channel
package inputc_pkg;

    typedef enum logic [2:0] {
        FT_NONE     = 3'd0,
        FT_HEAD     = 3'd1,
        FT_BODY     = 3'd2,
        FT_TAIL     = 3'd3,
        FT_HEADTAIL = 3'd4
    } flit_t;

    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_E = 3'd1;
    localparam logic [2:0] P_S = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACTIVE
    } state_t;

    // Flit layout from the MSB down: 3-bit type, dst x, dst y, payload.
    function automatic int type_lsb(input int dataw);
        return dataw - 3;
    endfunction

    function automatic int x_lsb(input int dataw, input int arrayw);
        return dataw - 3 - arrayw;
    endfunction

    function automatic int y_lsb(input int dataw, input int arrayw);
        return dataw - 3 - 2 * arrayw;
    endfunction

endpackage

// File: rtl/inputc_nvc_if.sv
// inputc_nvc_if: upstream link and switch-allocator signals of one physical input port
interface inputc_nvc_if #(
    parameter int DATAW = 32,
    parameter int NVC   = 2
);
    localparam int VW = $clog2(NVC);

    logic [DATAW-1:0] idata;
    logic             ivalid;
    logic [VW-1:0]    ivch;
    logic [NVC-1:0]   ordy;
    logic [NVC-1:0]   oack;
    logic [NVC-1:0]   olck;
    logic             req;
    logic [2:0]       port;
    logic [VW-1:0]    ovch;
    logic [DATAW-1:0] odata;
    logic             ovalid;
    logic             grt;
    logic [5*NVC-1:0] irdy;
    logic [5*NVC-1:0] ilck;

    modport master (
        output idata, ivalid, ivch, grt, irdy, ilck,
        input  ordy, oack, olck, req, port, ovch, odata, ovalid
    );

    modport slave (
        input  idata, ivalid, ivch, grt, irdy, ilck,
        output ordy, oack, olck, req, port, ovch, odata, ovalid
    );

endinterface

// File: rtl/inputc_nvc_vc_fifo.sv
// vc_fifo: per-VC flit FIFO; a push on a full FIFO is taken only when a pop happens the same cycle
module vc_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign rdata_o = mem_q[rp_q];
    assign wr      = push_i && (!full_o || pop_i);
    assign rd      = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) begin
                mem_q[wp_q] <= wdata_i;
                wp_q        <= wp_q + 1'b1;
            end
            if (rd) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

endmodule

// File: rtl/inputc_nvc.sv
// inputc_nvc: NVC-channel router input port with per-VC XY routing, packet FSMs and
// round-robin multiplexing onto the single switch-allocator request
module inputc_nvc
    import inputc_pkg::*;
#(
    parameter int DATAW  = 32,
    parameter int NVC    = 2,
    parameter int DEPTH  = 4,
    parameter int ARRAYW = 4,
    parameter int PCHID  = 0
) (
    input  logic              clk,
    input  logic              rst,
    inputc_nvc_if.slave       bus,
    input  logic [ARRAYW-1:0] my_xpos,
    input  logic [ARRAYW-1:0] my_ypos,
    output logic              err
);
    localparam int VW = $clog2(NVC);
    localparam int TL = type_lsb(DATAW);
    localparam int XL = x_lsb(DATAW, ARRAYW);
    localparam int YL = y_lsb(DATAW, ARRAYW);

    state_t           state_q [NVC];
    state_t           state_d [NVC];
    logic [2:0]       route_q [NVC];
    logic [2:0]       route_d [NVC];
    logic [DATAW-1:0] head    [NVC];
    logic [NVC-1:0]   push, pop, drop, full, empty, elig;
    logic [VW-1:0]    ptr_q, ptr_d, sel;
    logic             found, gnt, err_q, err_d;

    function automatic logic [2:0] xy_route(input logic [ARRAYW-1:0] dx, dy, mx, my);
        return dx > mx ? P_E : dx < mx ? P_W : dy > my ? P_S : dy < my ? P_N : P_L;
    endfunction

    for (genvar v = 0; v < NVC; v++) begin : g_vc
        assign push[v] = bus.ivalid && bus.ivch == VW'(v) && bus.idata[TL +: 3] != FT_NONE;
        vc_fifo #(.DW(DATAW), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[v]),
            .pop_i   (pop[v]),
            .wdata_i (bus.idata),
            .rdata_o (head[v]),
            .full_o  (full[v]),
            .empty_o (empty[v])
        );
    end

    // Search starts at the round-robin pointer so the last winner goes to the back.
    always_comb begin
        elig  = '0;
        found = 1'b0;
        sel   = '0;
        for (int v = 0; v < NVC; v++)
            elig[v] = state_q[v] == ST_ACTIVE && !empty[v] && bus.irdy[int'(route_q[v]) * NVC + v];
        for (int k = 0; k < NVC; k++)
            if (!found && elig[(int'(ptr_q) + k) % NVC]) begin
                found = 1'b1;
                sel   = VW'((int'(ptr_q) + k) % NVC);
            end
    end

    assign gnt   = bus.grt && found;
    assign ptr_d = !gnt ? ptr_q : sel == VW'(NVC - 1) ? '0 : sel + 1'b1;

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        pop     = '0;
        drop    = '0;
        for (int v = 0; v < NVC; v++) begin
            case (state_q[v])
                ST_IDLE: if (!empty[v]) begin
                    if (head[v][TL +: 3] == FT_HEAD || head[v][TL +: 3] == FT_HEADTAIL) begin
                        route_d[v] = xy_route(head[v][XL +: ARRAYW], head[v][YL +: ARRAYW], my_xpos, my_ypos);
                        state_d[v] = ST_WAIT;
                    end else begin
                        pop[v]  = 1'b1;
                        drop[v] = 1'b1;
                    end
                end
                ST_WAIT: if (!bus.ilck[int'(route_q[v]) * NVC + v]) state_d[v] = ST_ACTIVE;
                ST_ACTIVE: if (gnt && sel == VW'(v)) begin
                    pop[v] = 1'b1;
                    if (head[v][TL +: 3] == FT_TAIL || head[v][TL +: 3] == FT_HEADTAIL) state_d[v] = ST_IDLE;
                end
                default: state_d[v] = ST_IDLE;
            endcase
        end
    end

    // Overflow: a push that finds its FIFO full with no pop to make room is lost.
    assign err_d = err_q | (|drop) | (|(push & full & ~pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            err_q <= 1'b0;
            for (int v = 0; v < NVC; v++) begin
                state_q[v] <= ST_IDLE;
                route_q[v] <= P_N;
            end
        end else begin
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        bus.olck = '0;
        for (int v = 0; v < NVC; v++) bus.olck[v] = state_q[v] == ST_ACTIVE;
    end

    assign bus.ordy   = ~full;
    assign bus.oack   = pop;
    assign bus.req    = found;
    assign bus.port   = found ? route_q[sel] : P_N;
    assign bus.ovch   = sel;
    assign bus.ovalid = gnt;
    assign bus.odata  = gnt ? head[sel] : '0;
    assign err        = err_q;

endmodule

// File: tb/tb_inputc_nvc.sv
// tb_inputc_nvc: directed vectors for inputc_nvc (NVC=2, DEPTH=4) at router position (1,1)
module tb_inputc_nvc;
    localparam int DATAW = 32, NVC = 2, DEPTH = 4, ARRAYW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] my_x = 4'd1, my_y = 4'd1;
    logic       err;
    int         n_chk = 0, n_fail = 0;

    inputc_nvc_if #(.DATAW(DATAW), .NVC(NVC)) bus ();

    inputc_nvc #(.DATAW(DATAW), .NVC(NVC), .DEPTH(DEPTH), .ARRAYW(ARRAYW), .PCHID(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .my_xpos (my_x),
        .my_ypos (my_y),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fl(input logic [2:0] t, input logic [3:0] x, y, input logic [20:0] p);
        return {t, x, y, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic put(input logic v, input logic vc, input logic [31:0] d);
        bus.ivalid = v;
        bus.ivch   = vc;
        bus.idata  = d;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        put(1'b0, 1'b0, 32'd0);
        bus.grt  = 1'b0;
        bus.irdy = '1;
        bus.ilck = '0;
        cyc;
        cyc;
        rst = 1'b0;
    endtask

    logic [31:0] s2 [6];
    logic [31:0] s3 [6];
    logic [31:0] h, b, t;

    initial begin
        put(1'b0, 1'b0, 32'd0);
        bus.grt  = 1'b0;
        bus.irdy = '1;
        bus.ilck = '0;
        do_reset;
        #1;
        chk("rst_ordy", bus.ordy, 2'b11);
        chk("rst_req", bus.req, 0);
        chk("rst_err", err, 0);
        chk("rst_oack", bus.oack, 0);
        chk("rst_olck", bus.olck, 0);
        chk("rst_ovalid", bus.ovalid, 0);
        chk("rst_odata", bus.odata, 0);

        // three-flit packet on VC0 heading east
        h = fl(3'd1, 4'd2, 4'd1, 21'h11);
        b = fl(3'd2, 4'd0, 4'd0, 21'h12);
        t = fl(3'd3, 4'd0, 4'd0, 21'h13);
        cyc; put(1'b1, 1'b0, h);
        cyc; put(1'b1, 1'b0, b); #1;
        chk("s1_req_t1", bus.req, 0);
        cyc; put(1'b1, 1'b0, t); #1;
        chk("s1_req_t2", bus.req, 0);
        chk("s1_olck_t2", bus.olck, 0);
        cyc; put(1'b0, 1'b0, 32'd0); bus.grt = 1'b1; #1;
        chk("s1_req_t3", bus.req, 1);
        chk("s1_port", bus.port, 1);
        chk("s1_ovch", bus.ovch, 0);
        chk("s1_olck_t3", bus.olck, 2'b01);
        chk("s1_ovalid", bus.ovalid, 1);
        chk("s1_head", bus.odata, h);
        chk("s1_oack0", bus.oack, 2'b01);
        cyc; #1;
        chk("s1_body", bus.odata, b);
        chk("s1_oack1", bus.oack, 2'b01);
        cyc; #1;
        chk("s1_tail", bus.odata, t);
        chk("s1_oack2", bus.oack, 2'b01);
        cyc; #1;
        chk("s1_olck_end", bus.olck, 0);
        chk("s1_req_end", bus.req, 0);
        chk("s1_ovalid_end", bus.ovalid, 0);
        chk("s1_oack_end", bus.oack, 0);
        chk("s1_odata_end", bus.odata, 0);
        bus.grt = 1'b0;

        // two VCs interleaved under a held grant
        do_reset;
        s2[0] = fl(3'd1, 4'd2, 4'd1, 21'h20);
        s2[1] = fl(3'd1, 4'd1, 4'd2, 21'h21);
        s2[2] = fl(3'd2, 4'd0, 4'd0, 21'h22);
        s2[3] = fl(3'd2, 4'd0, 4'd0, 21'h23);
        s2[4] = fl(3'd3, 4'd0, 4'd0, 21'h24);
        s2[5] = fl(3'd3, 4'd0, 4'd0, 21'h25);
        for (int i = 0; i < 6; i++) begin
            cyc; put(1'b1, 1'(i % 2), s2[i]);
        end
        cyc; put(1'b0, 1'b0, 32'd0); bus.grt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("s2_ovch%0d", i), bus.ovch, 32'(i % 2));
            chk($sformatf("s2_odata%0d", i), bus.odata, s2[i]);
            cyc;
        end
        #1;
        chk("s2_req_end", bus.req, 0);
        chk("s2_olck_end", bus.olck, 0);
        bus.grt = 1'b0;

        // fill VC1 while stalled, push+pop on full, then overflow
        do_reset;
        bus.irdy = '0;
        s3[0] = fl(3'd1, 4'd2, 4'd1, 21'h31);
        for (int i = 1; i < 6; i++) s3[i] = fl(3'd2, 4'd0, 4'd0, 21'(32'h31 + i));
        for (int i = 0; i < 4; i++) begin
            cyc; put(1'b1, 1'b1, s3[i]);
        end
        cyc; put(1'b0, 1'b0, 32'd0); #1;
        chk("s3_ordy_full", bus.ordy, 2'b01);
        chk("s3_req_stall", bus.req, 0);
        cyc; cyc; #1;
        chk("s3_olck_stall", bus.olck, 2'b10);
        chk("s3_req_stall2", bus.req, 0);
        cyc; bus.irdy = '1; bus.grt = 1'b1; put(1'b1, 1'b1, s3[4]); #1;
        chk("s3_pp_req", bus.req, 1);
        chk("s3_pp_ovch", bus.ovch, 1);
        chk("s3_pp_odata", bus.odata, s3[0]);
        cyc; put(1'b0, 1'b0, 32'd0); bus.grt = 1'b0; bus.irdy = '0; #1;
        chk("s3_pp_err", err, 0);
        chk("s3_pp_ordy", bus.ordy, 2'b01);
        cyc; put(1'b1, 1'b1, s3[5]);
        cyc; put(1'b0, 1'b0, 32'd0); #1;
        chk("s3_ovf_err", err, 1);
        chk("s3_ovf_ordy", bus.ordy, 2'b01);
        bus.irdy = '1; bus.grt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("s3_drain%0d", i), bus.odata, s3[i+1]);
            chk($sformatf("s3_oack%0d", i), bus.oack, 2'b10);
            cyc;
        end
        #1;
        chk("s3_req_empty", bus.req, 0);
        chk("s3_ovalid_empty", bus.ovalid, 0);
        chk("s3_ordy_empty", bus.ordy, 2'b11);
        bus.grt = 1'b0;

        // downstream lock holds WAIT; later lock while ACTIVE is ignored; stray BODY dropped
        do_reset;
        #1;
        chk("s4_err_clr", err, 0);
        bus.ilck = 10'b00000_10000;
        h = fl(3'd4, 4'd1, 4'd3, 21'h41);
        cyc; put(1'b1, 1'b0, h);
        cyc; put(1'b0, 1'b0, 32'd0);
        cyc;
        cyc; #1;
        chk("s4_req_locked", bus.req, 0);
        chk("s4_olck_locked", bus.olck, 0);
        cyc; bus.ilck = '0; #1;
        chk("s4_req_release", bus.req, 0);
        cyc; bus.ilck = 10'b00000_10000; #1;
        chk("s4_olck_active", bus.olck, 2'b01);
        chk("s4_req_active", bus.req, 1);
        chk("s4_port", bus.port, 2);
        cyc; #1;
        chk("s4_lock_ignored", bus.req, 1);
        bus.grt = 1'b1; #1;
        chk("s4_odata", bus.odata, h);
        cyc; bus.grt = 1'b0; bus.ilck = '0; #1;
        chk("s4_olck_idle", bus.olck, 0);
        chk("s4_req_idle", bus.req, 0);
        b = fl(3'd2, 4'd0, 4'd0, 21'h42);
        cyc; put(1'b1, 1'b0, b);
        cyc; put(1'b0, 1'b0, 32'd0); #1;
        chk("s4_drop_oack", bus.oack, 2'b01);
        chk("s4_drop_req", bus.req, 0);
        cyc; #1;
        chk("s4_drop_err", err, 1);
        chk("s4_drop_ordy", bus.ordy, 2'b11);
        chk("s4_drop_olck", bus.olck, 0);
        chk("s4_drop_oack_end", bus.oack, 0);

        // local HEADTAIL, then reset mid-packet
        do_reset;
        #1;
        chk("s5_err_clr", err, 0);
        h = fl(3'd4, 4'd1, 4'd1, 21'h51);
        cyc; put(1'b1, 1'b0, h);
        cyc; put(1'b0, 1'b0, 32'd0);
        cyc;
        cyc; bus.grt = 1'b1; #1;
        chk("s5_req", bus.req, 1);
        chk("s5_port_local", bus.port, 4);
        chk("s5_odata", bus.odata, h);
        chk("s5_ovalid", bus.ovalid, 1);
        cyc; #1;
        chk("s5_req_single", bus.req, 0);
        chk("s5_olck_idle", bus.olck, 0);
        chk("s5_ovalid_single", bus.ovalid, 0);
        bus.grt = 1'b0;
        h = fl(3'd1, 4'd0, 4'd1, 21'h52);
        b = fl(3'd2, 4'd0, 4'd0, 21'h53);
        t = fl(3'd2, 4'd0, 4'd0, 21'h54);
        cyc; put(1'b1, 1'b1, h);
        cyc; put(1'b1, 1'b1, b);
        cyc; put(1'b1, 1'b1, t);
        cyc; put(1'b0, 1'b0, 32'd0); bus.grt = 1'b1; #1;
        chk("s5_port_west", bus.port, 3);
        chk("s5_ovch", bus.ovch, 1);
        chk("s5_mid_odata", bus.odata, h);
        cyc; bus.grt = 1'b0; rst = 1'b1; #1;
        chk("s5_olck_pre_rst", bus.olck, 2'b10);
        cyc; rst = 1'b0; bus.grt = 1'b1; #1;
        chk("s5_rst_ordy", bus.ordy, 2'b11);
        chk("s5_rst_req", bus.req, 0);
        chk("s5_rst_olck", bus.olck, 0);
        chk("s5_rst_oack", bus.oack, 0);
        chk("s5_rst_ovalid", bus.ovalid, 0);
        chk("s5_rst_odata", bus.odata, 0);
        chk("s5_rst_port", bus.port, 0);
        chk("s5_rst_ovch", bus.ovch, 0);
        chk("s5_rst_err", err, 0);
        bus.grt = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
